// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage sitting directly after the next-PC selector.
// Owns the architectural PC register, drives the instruction-memory address
// and captures the IF/ID pipeline register (pc, pc+4, inst, valid).
//
// Redirects (flag/npc_change) take priority over hazard stalls and squash
// the wrong-path IF/ID entry. When instruction memory is not ready, the
// redirect is parked in a pending register and replayed on the first ready
// cycle; a younger redirect overwrites an older parked one.
//
// Optional feature, selected by the macro IF_MISALIGN_TRAP_EN:
//   defined   : a redirect target with nonzero low bits sends the PC to
//               TRAP_VEC and records the target in the sticky
//               misalign_err / misalign_addr outputs.
//   undefined : the low two bits of every redirect target are cleared and
//               the misalign_* ports do not exist.
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        flag,
    input  logic [31:0] npc_change,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        misalign_err,
    output logic [31:0] misalign_addr,
`endif
    output logic        flush_id_ex
);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [31:0] pc_q,          pc_d;
    logic        pend_valid_q,  pend_valid_d;
    logic [31:0] pend_pc_q,     pend_pc_d;
    logic [31:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0] if_id_pc4_q,   if_id_pc4_d;
    logic [31:0] if_id_inst_q,  if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
`ifdef IF_MISALIGN_TRAP_EN
    logic        misalign_err_q,  misalign_err_d;
    logic [31:0] misalign_addr_q, misalign_addr_d;
`endif

    // ------------------------------------------------------------------
    // Redirect decode signals
    // ------------------------------------------------------------------
    logic        redir;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;
    logic [31:0] apply_pc;
    logic [31:0] pc_plus4;
`ifdef IF_MISALIGN_TRAP_EN
    logic        tgt_misaligned;
`else
    logic        unused_tgt_lsbs;
    logic [31:0] unused_trap_vec;
`endif

    // Resolve the active redirect: a fresh flag always beats a parked one,
    // and the PC value it would load once imem accepts it.
    always_comb begin
        redir    = flag | pend_valid_q;
        tgt_raw  = flag ? npc_change : pend_pc_q;
        pc_plus4 = pc_q + 32'd4;
`ifdef IF_MISALIGN_TRAP_EN
        tgt            = tgt_raw;
        tgt_misaligned = (tgt_raw[1:0] != 2'b00);
        apply_pc       = tgt_misaligned ? TRAP_VEC : tgt_raw;
`else
        tgt      = {tgt_raw[31:2], 2'b00};
        apply_pc = tgt;
`endif
    end

`ifndef IF_MISALIGN_TRAP_EN
    // Without the trap the low target bits and the trap vector are discarded.
    assign unused_tgt_lsbs = ^tgt_raw[1:0];
    assign unused_trap_vec = TRAP_VEC;
`endif

    // Next-state selection; branches are ordered so the first match wins:
    // redirect applied, redirect parked, stall, normal fetch, bubble.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
`ifdef IF_MISALIGN_TRAP_EN
        misalign_err_d  = misalign_err_q;
        misalign_addr_d = misalign_addr_q;
`endif

        if (redir && imem_ready) begin
            pc_d          = apply_pc;
            pend_valid_d  = 1'b0;
            if_id_valid_d = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
            if (tgt_misaligned) begin
                misalign_err_d  = 1'b1;
                misalign_addr_d = tgt_raw;
            end
`endif
        end else if (redir) begin
            pend_valid_d  = 1'b1;
            pend_pc_d     = tgt;
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            pc_d          = pc_q;
        end else if (imem_ready) begin
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4;
            if_id_inst_d  = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
        end else begin
            if_id_valid_d = 1'b0;
        end
    end

    // PC, pending-redirect and IF/ID registers with asynchronous reset.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= 32'h0000_0000;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_pc4_q   <= 32'h0000_0000;
            if_id_inst_q  <= 32'h0000_0000;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Sticky misalignment record, cleared only by reset.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= 32'h0000_0000;
        end else begin
            misalign_err_q  <= misalign_err_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign misalign_err  = misalign_err_q;
    assign misalign_addr = misalign_addr_q;
`endif

    // The imem address is the registered PC; flush is a pure function of a
    // fresh redirect so parked replays do not flush ID/EX a second time.
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;
    assign flush_id_ex = flag;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Table-driven bench for if_fetch_stage. Each record gives the inputs for
// one clock edge and the expected imem address and IF/ID contents after it.
// A hand-written sequence covers an asynchronous reset while a redirect is
// parked. Expectations for the misaligned-target vectors follow the macro
// IF_MISALIGN_TRAP_EN so the same bench serves both builds.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

   logic        cpu_clk;
   logic        cpu_rst;
   logic        flag;
   logic [31:0] npc_change;
   logic        stall;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] imem_addr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_inst;
   logic        if_id_valid;
   logic        flush_id_ex;
`ifdef IF_MISALIGN_TRAP_EN
   logic        misalign_err;
   logic [31:0] misalign_addr;
`endif

   typedef struct {
      logic        flag;
      logic [31:0] npc;
      logic        stall;
      logic        ready;
      logic [31:0] rdata;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
      logic [31:0] expPc4;
      logic [31:0] expInst;
   } vec_t;

   vec_t vecs[$];
   int   testsRun;
   int   testsFailed;

   if_fetch_stage #(
      .RESET_PC(RESET_PC),
      .TRAP_VEC(TRAP_VEC)
   ) dut (
      .cpu_clk      (cpu_clk),
      .cpu_rst      (cpu_rst),
      .flag         (flag),
      .npc_change   (npc_change),
      .stall        (stall),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .imem_addr    (imem_addr),
      .if_id_pc     (if_id_pc),
      .if_id_pc4    (if_id_pc4),
      .if_id_inst   (if_id_inst),
      .if_id_valid  (if_id_valid),
`ifdef IF_MISALIGN_TRAP_EN
      .misalign_err (misalign_err),
      .misalign_addr(misalign_addr),
`endif
      .flush_id_ex  (flush_id_ex)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      cpu_clk = 1'b0;
      forever #5 cpu_clk = ~cpu_clk;
   end

   // Compare one value and record the outcome.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Build one table record.
   function automatic vec_t mk(input logic f, input logic [31:0] npc,
                               input logic st, input logic rdy,
                               input logic [31:0] rd, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep,
                               input logic [31:0] ep4, input logic [31:0] ei);
      vec_t v;
      v.flag = f; v.npc = npc; v.stall = st; v.ready = rdy; v.rdata = rd;
      v.expAddr = ea; v.expValid = ev; v.expPc = ep; v.expPc4 = ep4;
      v.expInst = ei;
      return v;
   endfunction

   // Drive one vector between edges, check the combinational flush, clock
   // it, then check the registered state just after the edge.
   task automatic applyStimulus(input vec_t v, input int idx);
      @(negedge cpu_clk);
      flag       = v.flag;
      npc_change = v.npc;
      stall      = v.stall;
      imem_ready = v.ready;
      imem_rdata = v.rdata;
      #1;
      checkOutput($sformatf("v%0d flush_id_ex", idx), {31'd0, flush_id_ex},
                  {31'd0, v.flag});
      @(posedge cpu_clk);
      #1;
      checkOutput($sformatf("v%0d imem_addr", idx), imem_addr, v.expAddr);
      checkOutput($sformatf("v%0d if_id_valid", idx), {31'd0, if_id_valid},
                  {31'd0, v.expValid});
      if (v.expValid) begin
         checkOutput($sformatf("v%0d if_id_pc", idx), if_id_pc, v.expPc);
         checkOutput($sformatf("v%0d if_id_pc4", idx), if_id_pc4, v.expPc4);
         checkOutput($sformatf("v%0d if_id_inst", idx), if_id_inst, v.expInst);
      end
   endtask

   // Main test: table first, then the hand-written reset sequence.
   initial begin
      logic [31:0] misPc;
      testsRun    = 0;
      testsFailed = 0;
`ifdef IF_MISALIGN_TRAP_EN
      misPc = TRAP_VEC;
`else
      misPc = 32'h0000_0040;
`endif

      // Sequential fetch from reset.
      vecs.push_back(mk(0, 0, 0, 1, 32'hA000_0000, 32'h04, 1, 32'h00, 32'h04, 32'hA000_0000));
      vecs.push_back(mk(0, 0, 0, 1, 32'hA000_0004, 32'h08, 1, 32'h04, 32'h08, 32'hA000_0004));
      // Immediate redirect to 0x40 flushes IF/ID.
      vecs.push_back(mk(1, 32'h40, 0, 1, 32'hA000_0008, 32'h40, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hA000_0040, 32'h44, 1, 32'h40, 32'h44, 32'hA000_0040));
      // Stall holds PC and IF/ID.
      vecs.push_back(mk(0, 0, 1, 1, 32'hDEAD_BEEF, 32'h44, 1, 32'h40, 32'h44, 32'hA000_0040));
      // Redirect overrides stall.
      vecs.push_back(mk(1, 32'h60, 1, 1, 32'hDEAD_BEEF, 32'h60, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hA000_0060, 32'h64, 1, 32'h60, 32'h64, 32'hA000_0060));
      // imem not ready: bubble.
      vecs.push_back(mk(0, 0, 0, 0, 32'hDEAD_BEEF, 32'h64, 0, 0, 0, 0));
      // Redirect to 0x80 parked for three busy cycles, then applied.
      vecs.push_back(mk(1, 32'h80, 0, 0, 32'hDEAD_BEEF, 32'h64, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'hDEAD_BEEF, 32'h64, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'hDEAD_BEEF, 32'h64, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 32'h80, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hA000_0080, 32'h84, 1, 32'h80, 32'h84, 32'hA000_0080));
      // Younger redirect overwrites a parked one.
      vecs.push_back(mk(1, 32'hA0, 0, 0, 32'hDEAD_BEEF, 32'h84, 0, 0, 0, 0));
      vecs.push_back(mk(1, 32'hC0, 0, 0, 32'hDEAD_BEEF, 32'h84, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hDEAD_BEEF, 32'hC0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hA000_00C0, 32'hC4, 1, 32'hC0, 32'hC4, 32'hA000_00C0));
      // Misaligned target 0x42.
      vecs.push_back(mk(1, 32'h42, 0, 1, 32'hDEAD_BEEF, misPc, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hB000_0000, misPc + 32'd4, 1, misPc, misPc + 32'd4, 32'hB000_0000));
      // PC wraps at the top of the address space.
      vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'hC000_0000, 32'h00, 1, 32'hFFFF_FFFC, 32'h00, 32'hC000_0000));

      flag       = 1'b0;
      npc_change = 32'h0;
      stall      = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      cpu_rst    = 1'b1;
      repeat (2) @(posedge cpu_clk);
      #1;
      checkOutput("reset imem_addr", imem_addr, RESET_PC);
      checkOutput("reset if_id_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("reset if_id_pc", if_id_pc, 32'd0);
      checkOutput("reset if_id_inst", if_id_inst, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
      checkOutput("reset misalign_err", {31'd0, misalign_err}, 32'd0);
`endif
      @(negedge cpu_clk);
      cpu_rst = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i], i);
`ifdef IF_MISALIGN_TRAP_EN
         if (i == 17) begin
            checkOutput("misalign_err set", {31'd0, misalign_err}, 32'd1);
            checkOutput("misalign_addr", misalign_addr, 32'h0000_0042);
         end
         if (i == 20)
            checkOutput("misalign_err sticky", {31'd0, misalign_err}, 32'd1);
`endif
      end

      // Park a redirect, then assert reset asynchronously between edges:
      // the parked redirect must be discarded.
      @(negedge cpu_clk);
      flag       = 1'b1;
      npc_change = 32'h0000_0200;
      imem_ready = 1'b0;
      @(posedge cpu_clk);
      #2;
      flag    = 1'b0;
      cpu_rst = 1'b1;
      #1;
      checkOutput("async reset imem_addr", imem_addr, RESET_PC);
      checkOutput("async reset if_id_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
      checkOutput("async reset misalign_err", {31'd0, misalign_err}, 32'd0);
`endif
      @(negedge cpu_clk);
      cpu_rst    = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'hE000_0000;
      @(posedge cpu_clk);
      #1;
      checkOutput("post reset imem_addr", imem_addr, RESET_PC + 32'd4);
      checkOutput("post reset if_id_pc", if_id_pc, RESET_PC);
      checkOutput("post reset if_id_inst", if_id_inst, 32'hE000_0000);
      checkOutput("post reset if_id_valid", {31'd0, if_id_valid}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
